// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port CPU register file. It has two write ports
//            (port 0 with byte strobes, port 1 full-word plus busy clear),
//            NREAD combinational read ports, optional same-cycle write-to-read
//            bypass, an optional hardwired zero register, and a per-register
//            busy scoreboard for multi-cycle writeback.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       waddr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic [DATA_W/8-1:0]     wstrb0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic                    sb_set,
    input  logic [ADDR_W-1:0]       sb_addr,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic [NREAD-1:0]        rbusy,
    output logic                    busy_any
);

    localparam int NREG  = 2**ADDR_W;
    localparam int NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    logic              w_we0;
    logic              w_we1;
    logic              w_sb;
    logic [DATA_W-1:0] w_merge0;

    // Address 0 is the hardwired zero register only when ZERO_REG is set
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writes and scoreboard sets aimed at the zero register are dropped here
    assign w_we0 = we0    && !is_zero_reg(waddr0);
    assign w_we1 = we1    && !is_zero_reg(waddr1);
    assign w_sb  = sb_set && !is_zero_reg(sb_addr);

    // Merge the strobed bytes of port 0 into the word currently stored
    always_comb begin
        w_merge0 = mem_q[waddr0];
        for (int b = 0; b < NBYTE; b++) begin
            if (wstrb0[b]) begin
                w_merge0[8*b +: 8] = wdata0[8*b +: 8];
            end
        end
    end

    // Storage update; port 1 is applied last so it wins an address collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            if (w_we0) begin
                mem_q[waddr0] <= w_merge0;
            end
            if (w_we1) begin
                mem_q[waddr1] <= wdata1;
            end
        end
    end

    // Scoreboard next state: port 1 writeback clears, a set on the same
    // register in the same cycle overrides the clear
    always_comb begin
        busy_d = busy_q;
        if (w_we1) begin
            busy_d[waddr1] = 1'b0;
        end
        if (w_sb) begin
            busy_d[sb_addr] = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Registered state only; same-cycle bypass does not affect it
    assign busy_any = |busy_q;

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;
            logic              w_busy;

            assign w_addr = raddr[gi*ADDR_W +: ADDR_W];

            // Read mux with optional forwarding; port 1 overrides port 0,
            // and reset or the zero register forces both outputs low
            always_comb begin
                w_data = mem_q[w_addr];
                w_busy = busy_q[w_addr];
                if (BYPASS != 0) begin
                    if (w_we0 && (waddr0 == w_addr)) begin
                        w_data = w_merge0;
                    end
                    if (w_we1 && (waddr1 == w_addr)) begin
                        w_data = wdata1;
                        if (!(w_sb && (sb_addr == w_addr))) begin
                            w_busy = 1'b0;
                        end
                    end
                end
                if (rst || is_zero_reg(w_addr)) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = w_data;
            assign rbusy[gi]                  = w_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Directed self-checking bench for regfile_mp. The default
//            instance (bypass on) and a BYPASS=0 twin share the same
//            stimulus. A 64-bit, 3-read-port instance without a zero
//            register covers the generic configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic [3:0]  wstrb0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        busy_any;
    logic [63:0] nb_rdata;
    logic [1:0]  nb_rbusy;
    logic        nb_busy_any;

    logic         g_we0;
    logic [3:0]   g_waddr0;
    logic [63:0]  g_wdata0;
    logic [7:0]   g_wstrb0;
    logic         g_we1;
    logic [3:0]   g_waddr1;
    logic [63:0]  g_wdata1;
    logic         g_sb_set;
    logic [3:0]   g_sb_addr;
    logic [11:0]  g_raddr;
    logic [191:0] g_rdata;
    logic [2:0]   g_rbusy;
    logic         g_busy_any;

    int vectors;
    int miscompares;

    regfile_mp dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wstrb0(wstrb0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .busy_any(busy_any)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wstrb0(wstrb0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .raddr(raddr), .rdata(nb_rdata), .rbusy(nb_rbusy), .busy_any(nb_busy_any)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(4), .NREAD(3), .ZERO_REG(0)) dut_g (
        .clk(clk), .rst(rst),
        .we0(g_we0), .waddr0(g_waddr0), .wdata0(g_wdata0), .wstrb0(g_wstrb0),
        .we1(g_we1), .waddr1(g_waddr1), .wdata1(g_wdata1),
        .sb_set(g_sb_set), .sb_addr(g_sb_addr),
        .raddr(g_raddr), .rdata(g_rdata), .rbusy(g_rbusy), .busy_any(g_busy_any)
    );

    // 10 ns clock; inputs change on the falling edge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0; wstrb0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'hFFFFFFFF; wstrb0 = 4'hF;
        we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h55555555;
        sb_set = 1'b1; sb_addr = 5'd3;
        raddr = {5'd2, 5'd1};
        @(posedge clk); #1;
        vectors++;
        if (rdata !== 64'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected %h", rdata, 64'h0); end
        vectors++;
        if (rbusy !== 2'b00) begin miscompares++; $display("FAIL reset_rbusy: got %b expected 00", rbusy); end
        vectors++;
        if (busy_any !== 1'b0) begin miscompares++; $display("FAIL reset_busy_any: got %b expected 0", busy_any); end
        vectors++;
        if (nb_rdata !== 64'h0) begin miscompares++; $display("FAIL reset_nb_rdata: got %h expected %h", nb_rdata, 64'h0); end
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        vectors++;
        if (rdata !== 64'h0) begin miscompares++; $display("FAIL reset_writes_ignored: got %h expected %h", rdata, 64'h0); end
        vectors++;
        if (busy_any !== 1'b0) begin miscompares++; $display("FAIL reset_sb_ignored: got %b expected 0", busy_any); end
    endtask

    task automatic test_fill();
        logic [31:0] exp0;
        logic [31:0] exp1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            we0 = 1'b1; waddr0 = 5'(i); wstrb0 = 4'hF;
            wdata0 = (i == 0) ? 32'hDEADBEEF : 32'h00FF00FF + 32'(i);
        end
        @(negedge clk);
        idle();
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            #1;
            exp0 = (i == 0)  ? 32'h0 : 32'h00FF00FF + 32'(i);
            exp1 = (i == 31) ? 32'h0 : 32'h00FF00FF + 32'(31 - i);
            vectors++;
            if (rdata[31:0] !== exp0) begin miscompares++; $display("FAIL fill_port0 reg%0d: got %h expected %h", i, rdata[31:0], exp0); end
            vectors++;
            if (rdata[63:32] !== exp1) begin miscompares++; $display("FAIL fill_port1 reg%0d: got %h expected %h", 31 - i, rdata[63:32], exp1); end
        end
    endtask

    task automatic test_strobe_collision();
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h11223344; wstrb0 = 4'hF;
        @(negedge clk);
        wdata0 = 32'hAABBCCDD; wstrb0 = 4'b0101;
        raddr = {5'd0, 5'd5};
        #1;
        vectors++;
        if (rdata[31:0] !== 32'h11BB33DD) begin miscompares++; $display("FAIL strobe_bypass: got %h expected %h", rdata[31:0], 32'h11BB33DD); end
        @(negedge clk);
        idle();
        #1;
        vectors++;
        if (rdata[31:0] !== 32'h11BB33DD) begin miscompares++; $display("FAIL strobe_stored: got %h expected %h", rdata[31:0], 32'h11BB33DD); end
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1; wstrb0 = 4'hF;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2;
        raddr = {5'd0, 5'd7};
        #1;
        vectors++;
        if (rdata[31:0] !== 32'h2) begin miscompares++; $display("FAIL collision_bypass: got %h expected %h", rdata[31:0], 32'h2); end
        vectors++;
        if (nb_rdata[31:0] !== 32'h00FF0106) begin miscompares++; $display("FAIL collision_nb_old: got %h expected %h", nb_rdata[31:0], 32'h00FF0106); end
        @(negedge clk);
        idle();
        #1;
        vectors++;
        if (rdata[31:0] !== 32'h2) begin miscompares++; $display("FAIL collision_stored: got %h expected %h", rdata[31:0], 32'h2); end
        vectors++;
        if (nb_rdata[31:0] !== 32'h2) begin miscompares++; $display("FAIL collision_nb_stored: got %h expected %h", nb_rdata[31:0], 32'h2); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hCAFEF00D;
        raddr = {5'd0, 5'd9};
        #1;
        vectors++;
        if (rdata[31:0] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL bypass_we1: got %h expected %h", rdata[31:0], 32'hCAFEF00D); end
        vectors++;
        if (nb_rdata[31:0] !== 32'h00FF0108) begin miscompares++; $display("FAIL nobypass_before: got %h expected %h", nb_rdata[31:0], 32'h00FF0108); end
        @(posedge clk); #1;
        vectors++;
        if (nb_rdata[31:0] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL nobypass_after: got %h expected %h", nb_rdata[31:0], 32'hCAFEF00D); end
        @(negedge clk);
        idle();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h12345678; wstrb0 = 4'b0011;
        #1;
        vectors++;
        if (rdata[31:0] !== 32'hCAFE5678) begin miscompares++; $display("FAIL bypass_we0_merge: got %h expected %h", rdata[31:0], 32'hCAFE5678); end
        vectors++;
        if (nb_rdata[31:0] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL nobypass_we0_before: got %h expected %h", nb_rdata[31:0], 32'hCAFEF00D); end
        @(posedge clk); #1;
        vectors++;
        if (nb_rdata[31:0] !== 32'hCAFE5678) begin miscompares++; $display("FAIL nobypass_we0_after: got %h expected %h", nb_rdata[31:0], 32'hCAFE5678); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd12;
        raddr = {5'd12, 5'd0};
        @(negedge clk);
        idle();
        #1;
        vectors++;
        if (rbusy[1] !== 1'b1) begin miscompares++; $display("FAIL sb_rbusy_set: got %b expected 1", rbusy[1]); end
        vectors++;
        if (busy_any !== 1'b1) begin miscompares++; $display("FAIL sb_busy_any_set: got %b expected 1", busy_any); end
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h0; wstrb0 = 4'hF;
        @(posedge clk); #1;
        vectors++;
        if (rbusy[1] !== 1'b1) begin miscompares++; $display("FAIL sb_we0_no_clear: got %b expected 1", rbusy[1]); end
        @(negedge clk);
        idle();
        we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h5A5A5A5A;
        #1;
        vectors++;
        if (rbusy[1] !== 1'b0) begin miscompares++; $display("FAIL sb_bypass_clear: got %b expected 0", rbusy[1]); end
        vectors++;
        if (busy_any !== 1'b1) begin miscompares++; $display("FAIL sb_busy_any_registered: got %b expected 1", busy_any); end
        vectors++;
        if (nb_rbusy[1] !== 1'b1) begin miscompares++; $display("FAIL sb_nobypass_busy: got %b expected 1", nb_rbusy[1]); end
        @(posedge clk); #1;
        vectors++;
        if (busy_any !== 1'b0) begin miscompares++; $display("FAIL sb_busy_any_cleared: got %b expected 0", busy_any); end
        @(negedge clk);
        idle();
        sb_set = 1'b1; sb_addr = 5'd12;
        we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h0BADF00D;
        @(posedge clk); #1;
        vectors++;
        if (rbusy[1] !== 1'b1) begin miscompares++; $display("FAIL sb_set_wins: got %b expected 1", rbusy[1]); end
        vectors++;
        if (busy_any !== 1'b1) begin miscompares++; $display("FAIL sb_set_wins_any: got %b expected 1", busy_any); end
        vectors++;
        if (rdata[63:32] !== 32'h0BADF00D) begin miscompares++; $display("FAIL sb_set_data_written: got %h expected %h", rdata[63:32], 32'h0BADF00D); end
        @(negedge clk);
        idle();
        we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h0BADF00D;
        sb_set = 1'b1; sb_addr = 5'd0;
        @(posedge clk); #1;
        vectors++;
        if (busy_any !== 1'b0) begin miscompares++; $display("FAIL sb_zero_reg_dropped: got %b expected 0", busy_any); end
        vectors++;
        if (rbusy[0] !== 1'b0) begin miscompares++; $display("FAIL sb_zero_reg_rbusy: got %b expected 0", rbusy[0]); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd3;
        @(negedge clk);
        sb_addr = 5'd4;
        @(negedge clk);
        idle();
        raddr = {5'd4, 5'd3};
        #1;
        vectors++;
        if (rbusy !== 2'b11) begin miscompares++; $display("FAIL areset_pre_rbusy: got %b expected 11", rbusy); end
        vectors++;
        if (busy_any !== 1'b1) begin miscompares++; $display("FAIL areset_pre_busy_any: got %b expected 1", busy_any); end
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'hFFFFFFFF; wstrb0 = 4'hF;
        raddr = {5'd3, 5'd20};
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (rdata !== 64'h0) begin miscompares++; $display("FAIL areset_rdata: got %h expected %h", rdata, 64'h0); end
        vectors++;
        if (rbusy !== 2'b00) begin miscompares++; $display("FAIL areset_rbusy: got %b expected 00", rbusy); end
        vectors++;
        if (busy_any !== 1'b0) begin miscompares++; $display("FAIL areset_busy_any: got %b expected 0", busy_any); end
        vectors++;
        if (nb_rdata !== 64'h0) begin miscompares++; $display("FAIL areset_nb_rdata: got %h expected %h", nb_rdata, 64'h0); end
        #1 we0 = 1'b0;
        #1 rst = 1'b0;
        idle();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            raddr = {5'(c + 1), 5'(20 - c)};
            @(posedge clk); #1;
            vectors++;
            if (rdata !== 64'h0) begin miscompares++; $display("FAIL areset_readback cycle%0d: got %h expected %h", c, rdata, 64'h0); end
            vectors++;
            if (rbusy !== 2'b00) begin miscompares++; $display("FAIL areset_readback_rbusy cycle%0d: got %b expected 00", c, rbusy); end
            vectors++;
            if (busy_any !== 1'b0) begin miscompares++; $display("FAIL areset_readback_busy_any cycle%0d: got %b expected 0", c, busy_any); end
        end
    endtask

    task automatic test_generic();
        @(negedge clk);
        g_we0 = 1'b1; g_waddr0 = 4'd0; g_wdata0 = 64'h0123456789ABCDEF; g_wstrb0 = 8'hFF;
        g_raddr = 12'h000;
        #1;
        for (int p = 0; p < 3; p++) begin
            vectors++;
            if (g_rdata[p*64 +: 64] !== 64'h0123456789ABCDEF) begin miscompares++; $display("FAIL generic_bypass port%0d: got %h expected %h", p, g_rdata[p*64 +: 64], 64'h0123456789ABCDEF); end
        end
        @(negedge clk);
        g_we0 = 1'b0; g_wstrb0 = '0; g_wdata0 = '0;
        #1;
        for (int p = 0; p < 3; p++) begin
            vectors++;
            if (g_rdata[p*64 +: 64] !== 64'h0123456789ABCDEF) begin miscompares++; $display("FAIL generic_stored port%0d: got %h expected %h", p, g_rdata[p*64 +: 64], 64'h0123456789ABCDEF); end
        end
        vectors++;
        if (g_rbusy !== 3'b000) begin miscompares++; $display("FAIL generic_rbusy: got %b expected 000", g_rbusy); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        raddr = '0;
        g_we0 = 1'b0; g_waddr0 = '0; g_wdata0 = '0; g_wstrb0 = '0;
        g_we1 = 1'b0; g_waddr1 = '0; g_wdata1 = '0;
        g_sb_set = 1'b0; g_sb_addr = '0; g_raddr = '0;
        test_reset();
        test_fill();
        test_strobe_collision();
        test_bypass();
        test_scoreboard();
        test_async_reset();
        test_generic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Generalised in data width, register count and read-port count.
- Adds a second write port, byte strobes on write port 0, optional write-to-read bypass, optional hardwired zero register, and a per-register busy scoreboard for multi-cycle writeback.
- Sits in the decode/writeback stage of the CPU datapath.

Parameters:
- DATA_W, 32: register width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; register count is 2**ADDR_W.
- NREAD, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, is never busy.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- we0  in  1  write enable, port 0 (ALU writeback).
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- wstrb0  in  DATA_W/8  byte strobes, port 0; bit k covers bits [8k+7:8k].
- we1  in  1  write enable, port 1 (late/load writeback); also clears busy.
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1 (always a full word).
- sb_set  in  1  mark register sb_addr busy.
- sb_addr  in  ADDR_W  scoreboard set address.
- raddr  in  NREAD*ADDR_W  read addresses; port i occupies slice [i*ADDR_W +: ADDR_W].
- rdata  out  NREAD*DATA_W  read data; port i occupies slice [i*DATA_W +: DATA_W].
- rbusy  out  NREAD  per-port flag: the addressed register is pending.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset:
  - rst high asynchronously clears all registers and all busy bits.
  - While rst is high, rdata = 0, rbusy = 0 and busy_any = 0, and all writes and sb_set are ignored.
  - Writes resume at the first rising edge after rst deasserts.
- Storage:
  - Registers update on the rising edge of clk.
  - we0 writes only the bytes whose wstrb0 bit is 1; other bytes hold their value.
  - we1 writes the full word.
- Write collision: we0 and we1 to the same address in the same cycle → port 1 wins on every byte; port 0 data is discarded.
- Zero register: with ZERO_REG=1, writes to address 0 are dropped, sb_set to address 0 is dropped, and reads of address 0 return 0.
- Read:
  - Combinational with zero cycles of latency; rdata reflects storage as of the last edge.
  - With BYPASS=1, if a read address matches an active write address in the same cycle, rdata returns the post-write value: strobe-merged for port 0, full word for port 1, and port 1 taking priority on a collision. The zero register is never bypassed.
  - With BYPASS=0, the new value appears the cycle after the edge.
- Scoreboard:
  - One busy bit per register.
  - At an edge, sb_set sets busy[sb_addr], and we1 clears busy[waddr1].
  - When sb_set and we1 target the same address in the same cycle, set wins: the bit ends at 1, and the data is still written.
  - we0 never affects busy bits.
  - rbusy[i] = busy[raddr_i], except with BYPASS=1 when we1 is clearing that address this cycle and sb_set is not targeting it, rbusy[i] = 0.
  - busy_any is registered-state based and does not include same-cycle bypass.
- Read ports are independent: any number of ports may address the same register.
- The block contains no internal FSM beyond the storage and busy registers.
- Expected size: 150–300 lines of RTL.

Test Plan:
- Reset and fill:
  - Stimulus: assert rst, then deassert; write 32'h00FF00FF+i to register i (i = 1..31) via we0 with wstrb0=4'hF; read all registers through both ports.
  - Required: register i reads 32'h00FF00FF+i, and register 0 reads 0 even after a write of 32'hDEADBEEF to address 0.
- Byte strobe and collision:
  - Stimulus: preload register 5 = 32'h11223344; apply we0 to register 5 with wdata0=32'hAABBCCDD, wstrb0=4'b0101.
  - Required: register 5 = 32'h11BB33DD.
  - Stimulus: in the same cycle, apply we0=32'h1 and we1=32'h2 to register 7.
  - Required: register 7 = 32'h2.
- Bypass:
  - Stimulus: BYPASS=1; write 32'hCAFEF00D to register 9 via we1 while raddr port 0 = 9 in the same cycle.
  - Required: rdata port 0 = 32'hCAFEF00D before the edge.
  - Stimulus: repeat with BYPASS=0.
  - Required: the old value is seen before the edge and the new value after it.
- Scoreboard:
  - Stimulus: sb_set on register 12; one cycle later read register 12.
  - Required: rbusy = 1 and busy_any = 1.
  - Stimulus: apply we1 to register 12.
  - Required: rbusy = 0 in the same cycle with BYPASS=1, and busy_any = 0 after the edge.
  - Stimulus: sb_set and we1 on register 12 in the same cycle.
  - Required: the busy bit remains 1.
- Asynchronous reset mid-operation:
  - Stimulus: with registers 1..31 written and registers 3 and 4 busy, pulse rst for 3 ns between clock edges while we0 is active.
  - Required: all rdata = 0 and busy_any = 0 immediately, the in-flight write is lost, and an 8-cycle readback shows all zeros.
- Generic:
  - Stimulus: instantiate with DATA_W=64, ADDR_W=4, NREAD=3, ZERO_REG=0; write 64'h0123456789ABCDEF to register 0 and read it on all three ports.
  - Required: all three ports return the written value.
